// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs a signed immediate plus register/opcode
// fields into a 32-bit instruction word using the decode-stage ImmSrc format
// codes. One registered output stage with valid/ready handshake on both sides
// and saturating delivery/error counters.
module instr_encoder #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       fmt,
    input  logic [6:0]       opcode,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [2:0]       funct3,
    input  logic [31:0]      imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [CNT_W-1:0] enc_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    // ImmSrc format codes shared with the decode stage
    localparam logic [2:0] FmtI = 3'b000;
    localparam logic [2:0] FmtS = 3'b001;
    localparam logic [2:0] FmtB = 3'b010;
    localparam logic [2:0] FmtJ = 3'b011;
    localparam logic [2:0] FmtU = 3'b100;

    localparam logic [31:0] Nop = 32'h0000_0013;

    // Signed immediate limits
    localparam logic signed [31:0] ImmIsMin = -32'sd2048;
    localparam logic signed [31:0] ImmIsMax = 32'sd2047;
    localparam logic signed [31:0] ImmBMin  = -32'sd4096;
    localparam logic signed [31:0] ImmBMax  = 32'sd4094;
    localparam logic signed [31:0] ImmJMin  = -32'sd1048576;
    localparam logic signed [31:0] ImmJMax  = 32'sd1048574;

    logic             outValidQ;
    logic [31:0]      outInstrQ;
    logic             outErrQ;
    logic [CNT_W-1:0] encCntQ;
    logic [CNT_W-1:0] errCntQ;

    logic [31:0]      encWord;
    logic             encErr;
    logic signed [31:0] immS;
    logic             deliver;

    assign immS     = $signed(imm);
    assign in_ready = !outValidQ || out_ready;
    assign deliver  = outValidQ && out_ready;

    // Encode the request; out-of-range values are still packed from truncated bits
    always_comb begin
        encWord = Nop;
        encErr  = 1'b1;
        case (fmt)
            FmtI: begin
                encWord = {imm[11:0], rs1, funct3, rd, opcode};
                encErr  = (immS < ImmIsMin) || (immS > ImmIsMax);
            end
            FmtS: begin
                encWord = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                encErr  = (immS < ImmIsMin) || (immS > ImmIsMax);
            end
            FmtB: begin
                encWord = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                encErr  = (immS < ImmBMin) || (immS > ImmBMax) || imm[0];
            end
            FmtJ: begin
                encWord = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                encErr  = (immS < ImmJMin) || (immS > ImmJMax) || imm[0];
            end
            FmtU: begin
                encWord = {imm[31:12], rd, opcode};
                encErr  = (imm[11:0] != 12'd0);
            end
            default: begin
                encWord = Nop;
                encErr  = 1'b1;
            end
        endcase
    end

    // Output stage: load on accept, drop valid on drain, hold while stalled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outValidQ <= 1'b0;
            outInstrQ <= Nop;
            outErrQ   <= 1'b0;
        end else if (in_ready) begin
            outValidQ <= in_valid;
            if (in_valid) begin
                outInstrQ <= encWord;
                outErrQ   <= encErr;
            end
        end
    end

    // Saturating statistics counters, stepped on each delivered word
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            encCntQ <= '0;
            errCntQ <= '0;
        end else if (deliver) begin
            if (encCntQ != '1) begin
                encCntQ <= encCntQ + CNT_W'(1);
            end
            if (outErrQ && (errCntQ != '1)) begin
                errCntQ <= errCntQ + CNT_W'(1);
            end
        end
    end

    assign out_valid = outValidQ;
    assign out_instr = outInstrQ;
    assign out_err   = outErrQ;
    assign enc_cnt   = encCntQ;
    assign err_cnt   = errCntQ;

endmodule
